// File: rtl/pp_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pp_mon_pkg
// Description : Shared types, defaults and saturating-increment helper for
//               the pipelined-loop status monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package pp_mon_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int STATE_W_DEF = 30;
    localparam int SAT_W       = 64;

    typedef enum logic [0:0] {
        LOOP_IDLE   = 1'b0,
        LOOP_ACTIVE = 1'b1
    } loop_st_e;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max_value);
        return (value >= max_value) ? max_value : value + SAT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import pp_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [SAT_W-1:0] c_MAX = SAT_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] r_cnt;

    // clr together with inc restarts the count at 1, not 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            r_cnt <= CNT_W'(sat_inc(SAT_W'(r_cnt), c_MAX));
        end
    end

    assign count = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pp_loop_status_tracker.sv
`default_nettype none
// ============================================================================
// Module      : pp_loop_status_tracker
// Description : Passive observer of an HLS block handshake and one pipelined
//               loop; keeps saturating transaction/iteration/latency counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_loop_status_tracker
    import pp_mon_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               finish,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] pre_loop_state0,
    input  logic               pre_states_valid,
    input  logic [STATE_W-1:0] post_loop_state0,
    input  logic               post_states_valid,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic               iter_start_enable,
    input  logic               iter_start_block,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic               iter_end_enable,
    input  logic               iter_end_block,
    input  logic [STATE_W-1:0] loop_quit_state,
    input  logic               quit_at_end,
    output logic [CNT_W-1:0]   mod_starts,
    output logic [CNT_W-1:0]   mod_dones,
    output logic [CNT_W-1:0]   mod_busy_cyc,
    output logic [CNT_W-1:0]   mod_last_lat,
    output logic [CNT_W-1:0]   loop_entries,
    output logic [CNT_W-1:0]   iters_started,
    output logic [CNT_W-1:0]   iters_ended,
    output logic [CNT_W-1:0]   loop_cyc,
    output logic               loop_active,
    output logic               mod_busy,
    output logic               done_flag
);

    localparam logic [0:0]       c_ST_IDLE   = LOOP_IDLE;
    localparam logic [0:0]       c_ST_ACTIVE = LOOP_ACTIVE;
    localparam logic [SAT_W-1:0] c_MAX       = SAT_W'({CNT_W{1'b1}});

    // An all-zero state constant means "unused" and must never match.
    function automatic logic st_match(input logic [STATE_W-1:0] cur,
                                      input logic [STATE_W-1:0] ref_state);
        return (ref_state != '0) && (cur == ref_state);
    endfunction

    logic [0:0]         r_loop_st;
    logic [STATE_W-1:0] r_prev_state;
    logic               r_end_in_quit;
    logic               r_done;
    logic               r_busy;
    logic [CNT_W-1:0]   r_last_lat;

    logic               w_run;
    logic               w_iter_start;
    logic               w_iter_end;
    logic               w_active;
    logic               w_entry;
    logic               w_exit;
    logic               w_in_loop;
    logic               w_inc_started;
    logic               w_inc_ended;
    logic               w_start_ev;
    logic               w_done_ev;
    logic               w_first;
    logic               w_busy_any;
    logic [CNT_W-1:0]   w_lat;
    logic [CNT_W-1:0]   w_lat_next;

    // The edge that samples finish is itself frozen.
    assign w_run = !r_done && !finish;

    assign w_iter_start = st_match(cur_state, iter_start_state) && iter_start_enable && !iter_start_block;
    assign w_iter_end   = st_match(cur_state, iter_end_state) && iter_end_enable && !iter_end_block;

    assign w_active  = (r_loop_st == c_ST_ACTIVE);
    assign w_entry   = (r_loop_st == c_ST_IDLE) && w_iter_start
                       && (!pre_states_valid || st_match(r_prev_state, pre_loop_state0));
    assign w_exit    = w_active && post_states_valid && st_match(cur_state, post_loop_state0)
                       && (!quit_at_end || r_end_in_quit);
    assign w_in_loop = w_active || w_entry;

    // A retire is only credited if it cannot overtake the issue count.
    assign w_inc_started = w_in_loop && w_iter_start;
    assign w_inc_ended   = w_in_loop && w_iter_end && ((iters_ended < iters_started) || w_inc_started);

    assign w_start_ev = ap_start && ap_ready;
    assign w_done_ev  = ap_done && ap_continue;
    assign w_first    = ap_start && !r_busy;
    assign w_busy_any = r_busy || w_first;
    assign w_lat_next = w_first ? CNT_W'(1) : CNT_W'(sat_inc(SAT_W'(w_lat), c_MAX));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_loop_st     <= c_ST_IDLE;
            r_prev_state  <= '0;
            r_end_in_quit <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_last_lat    <= '0;
        end else if (!r_done) begin
            if (finish) begin
                r_done <= 1'b1;
            end else begin
                r_prev_state  <= cur_state;
                r_end_in_quit <= w_iter_end && st_match(cur_state, loop_quit_state);
                if (w_done_ev) begin
                    r_busy <= 1'b0;
                end else if (w_first) begin
                    r_busy <= 1'b1;
                end
                if (w_done_ev && w_busy_any) begin
                    r_last_lat <= w_lat_next;
                end
                if (w_entry) begin
                    r_loop_st <= c_ST_ACTIVE;
                end else if (w_exit) begin
                    r_loop_st <= c_ST_IDLE;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_lat (
        .clock(clock), .reset(reset), .clr(w_run && w_first),
        .inc(w_run && w_busy_any), .count(w_lat));

    sat_counter #(.CNT_W(CNT_W)) u_mod_starts (
        .clock(clock), .reset(reset), .clr(1'b0),
        .inc(w_run && w_start_ev), .count(mod_starts));

    sat_counter #(.CNT_W(CNT_W)) u_mod_dones (
        .clock(clock), .reset(reset), .clr(1'b0),
        .inc(w_run && w_done_ev), .count(mod_dones));

    sat_counter #(.CNT_W(CNT_W)) u_mod_busy_cyc (
        .clock(clock), .reset(reset), .clr(1'b0),
        .inc(w_run && w_busy_any), .count(mod_busy_cyc));

    sat_counter #(.CNT_W(CNT_W)) u_loop_entries (
        .clock(clock), .reset(reset), .clr(1'b0),
        .inc(w_run && w_entry), .count(loop_entries));

    sat_counter #(.CNT_W(CNT_W)) u_iters_started (
        .clock(clock), .reset(reset), .clr(1'b0),
        .inc(w_run && w_inc_started), .count(iters_started));

    sat_counter #(.CNT_W(CNT_W)) u_iters_ended (
        .clock(clock), .reset(reset), .clr(1'b0),
        .inc(w_run && w_inc_ended), .count(iters_ended));

    sat_counter #(.CNT_W(CNT_W)) u_loop_cyc (
        .clock(clock), .reset(reset), .clr(1'b0),
        .inc(w_run && w_active), .count(loop_cyc));

    assign mod_last_lat = r_last_lat;
    assign loop_active  = w_active;
    assign mod_busy     = r_busy;
    assign done_flag    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pp_loop_status_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pp_loop_status_tracker
// Description : Directed self-checking bench for pp_loop_status_tracker,
//               with a second 4-bit-counter instance for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_loop_status_tracker;

    localparam int STATE_W = 30;
    localparam int CNT_W   = 32;
    localparam logic [STATE_W-1:0] c_S_IDLE = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_S_PRE  = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_S_ITER = STATE_W'(4);
    localparam logic [STATE_W-1:0] c_S_POST = STATE_W'(8);

    logic clock = 1'b0;
    logic reset, finish, ap_start, ap_ready, ap_done, ap_continue;
    logic [STATE_W-1:0] cur_state, pre_loop_state0, post_loop_state0;
    logic [STATE_W-1:0] iter_start_state, iter_end_state, loop_quit_state;
    logic pre_states_valid, post_states_valid, quit_at_end;
    logic iter_start_enable, iter_start_block, iter_end_enable, iter_end_block;

    logic [CNT_W-1:0] mod_starts, mod_dones, mod_busy_cyc, mod_last_lat;
    logic [CNT_W-1:0] loop_entries, iters_started, iters_ended, loop_cyc;
    logic loop_active, mod_busy, done_flag;

    logic [3:0] q4_mod_starts, q4_mod_dones, q4_mod_busy_cyc, q4_mod_last_lat;
    logic [3:0] q4_loop_entries, q4_iters_started, q4_iters_ended, q4_loop_cyc;
    logic q4_loop_active, q4_mod_busy, q4_done_flag;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    pp_loop_status_tracker #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .pre_loop_state0(pre_loop_state0), .pre_states_valid(pre_states_valid),
        .post_loop_state0(post_loop_state0), .post_states_valid(post_states_valid),
        .iter_start_state(iter_start_state), .iter_start_enable(iter_start_enable),
        .iter_start_block(iter_start_block), .iter_end_state(iter_end_state),
        .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
        .loop_quit_state(loop_quit_state), .quit_at_end(quit_at_end),
        .mod_starts(mod_starts), .mod_dones(mod_dones), .mod_busy_cyc(mod_busy_cyc),
        .mod_last_lat(mod_last_lat), .loop_entries(loop_entries), .iters_started(iters_started),
        .iters_ended(iters_ended), .loop_cyc(loop_cyc), .loop_active(loop_active),
        .mod_busy(mod_busy), .done_flag(done_flag));

    pp_loop_status_tracker #(.STATE_W(STATE_W), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .pre_loop_state0(pre_loop_state0), .pre_states_valid(pre_states_valid),
        .post_loop_state0(post_loop_state0), .post_states_valid(post_states_valid),
        .iter_start_state(iter_start_state), .iter_start_enable(iter_start_enable),
        .iter_start_block(iter_start_block), .iter_end_state(iter_end_state),
        .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
        .loop_quit_state(loop_quit_state), .quit_at_end(quit_at_end),
        .mod_starts(q4_mod_starts), .mod_dones(q4_mod_dones), .mod_busy_cyc(q4_mod_busy_cyc),
        .mod_last_lat(q4_mod_last_lat), .loop_entries(q4_loop_entries),
        .iters_started(q4_iters_started), .iters_ended(q4_iters_ended), .loop_cyc(q4_loop_cyc),
        .loop_active(q4_loop_active), .mod_busy(q4_mod_busy), .done_flag(q4_done_flag));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_loop(input logic [STATE_W-1:0] cs, input logic ise, input logic isb,
                              input logic iee, input logic ieb);
        cur_state         = cs;
        iter_start_enable = ise;
        iter_start_block  = isb;
        iter_end_enable   = iee;
        iter_end_block    = ieb;
        tick();
    endtask

    initial begin
        reset = 1'b1; finish = 1'b0;
        ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b1;
        cur_state = c_S_IDLE;
        pre_loop_state0 = c_S_PRE;   pre_states_valid  = 1'b1;
        post_loop_state0 = c_S_POST; post_states_valid = 1'b1;
        iter_start_state = c_S_ITER; iter_end_state = c_S_ITER; loop_quit_state = c_S_ITER;
        quit_at_end = 1'b1;
        iter_start_enable = 1'b0; iter_start_block = 1'b0;
        iter_end_enable = 1'b0;   iter_end_block = 1'b0;
        tick();
        tick();
        chk("rst_mod_starts", mod_starts, 0);
        chk("rst_loop_active", loop_active, 0);
        chk("rst_done_flag", done_flag, 0);
        chk("rst_mod_busy", mod_busy, 0);
        reset = 1'b0;

        // Module transaction: start held 3 cycles, ready on the 3rd, done 5 later.
        for (int i = 1; i <= 3; i++) begin
            ap_start = 1'b1;
            ap_ready = (i == 3);
            tick();
            if (i == 1) chk("busy_after_start", mod_busy, 1);
        end
        ap_start = 1'b0; ap_ready = 1'b0;
        repeat (4) tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        chk("mod_starts_1", mod_starts, 1);
        chk("mod_dones_1", mod_dones, 1);
        chk("mod_last_lat_8", mod_last_lat, 8);
        chk("mod_busy_cyc_8", mod_busy_cyc, 8);
        chk("busy_cleared", mod_busy, 0);

        // Start and done in the same idle cycle.
        ap_start = 1'b1; ap_ready = 1'b1; ap_done = 1'b1;
        tick();
        ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
        chk("mod_starts_2", mod_starts, 2);
        chk("mod_dones_2", mod_dones, 2);
        chk("mod_last_lat_1", mod_last_lat, 1);
        chk("mod_busy_cyc_9", mod_busy_cyc, 9);
        chk("busy_same_cycle", mod_busy, 0);

        // First loop: 10 issues, 10 retires, exit via post state.
        drive_loop(c_S_PRE, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive_loop(c_S_ITER, 1, 0, 0, 0);
            if (i == 0) chk("entry_active", loop_active, 1);
        end
        chk("iters_started_10", iters_started, 10);
        chk("iters_ended_0", iters_ended, 0);
        for (int i = 0; i < 10; i++) drive_loop(c_S_ITER, 0, 0, 1, 0);
        chk("iters_ended_10", iters_ended, 10);
        drive_loop(c_S_POST, 0, 0, 0, 0);
        chk("loop_exit", loop_active, 0);
        chk("loop_entries_1", loop_entries, 1);
        chk("loop_cyc_20", loop_cyc, 20);

        // Second loop: post state without a preceding retire must not exit.
        drive_loop(c_S_PRE, 0, 0, 0, 0);
        drive_loop(c_S_ITER, 1, 0, 0, 0);
        drive_loop(c_S_ITER, 1, 0, 0, 0);
        chk("loop_entries_2", loop_entries, 2);
        drive_loop(c_S_POST, 0, 0, 0, 0);
        chk("no_quit_active", loop_active, 1);
        chk("loop_cyc_22", loop_cyc, 22);

        // Issue stage stalled for 4 cycles.
        repeat (4) drive_loop(c_S_ITER, 1, 1, 0, 0);
        chk("stall_started_12", iters_started, 12);
        chk("stall_loop_cyc_26", loop_cyc, 26);
        drive_loop(c_S_ITER, 1, 0, 0, 0);
        chk("unstall_started_13", iters_started, 13);

        // Five retires against three outstanding issues.
        repeat (5) drive_loop(c_S_ITER, 0, 0, 1, 0);
        chk("ended_capped_13", iters_ended, 13);
        chk("loop_cyc_32", loop_cyc, 32);
        chk("sat4_loop_cyc", q4_loop_cyc, 15);

        // Freeze on finish.
        finish = 1'b1; ap_start = 1'b1; ap_ready = 1'b1;
        drive_loop(c_S_ITER, 1, 0, 1, 0);
        chk("done_flag_set", done_flag, 1);
        chk("finish_edge_started", iters_started, 13);
        finish = 1'b0;
        repeat (3) drive_loop(c_S_ITER, 1, 0, 1, 0);
        ap_start = 1'b0; ap_ready = 1'b0;
        chk("frozen_started", iters_started, 13);
        chk("frozen_ended", iters_ended, 13);
        chk("frozen_loop_cyc", loop_cyc, 32);
        chk("frozen_mod_starts", mod_starts, 2);
        chk("done_flag_held", done_flag, 1);

        // Reset clears everything.
        cur_state = c_S_IDLE;
        iter_start_enable = 1'b0; iter_end_enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_mod_starts", mod_starts, 0);
        chk("rst2_mod_dones", mod_dones, 0);
        chk("rst2_mod_busy_cyc", mod_busy_cyc, 0);
        chk("rst2_mod_last_lat", mod_last_lat, 0);
        chk("rst2_loop_entries", loop_entries, 0);
        chk("rst2_iters_started", iters_started, 0);
        chk("rst2_iters_ended", iters_ended, 0);
        chk("rst2_loop_cyc", loop_cyc, 0);
        chk("rst2_loop_active", loop_active, 0);
        chk("rst2_done_flag", done_flag, 0);

        // 20 iterations: 32-bit counts through, 4-bit saturates at 15.
        drive_loop(c_S_PRE, 0, 0, 0, 0);
        repeat (20) drive_loop(c_S_ITER, 1, 0, 0, 0);
        chk("wide_started_20", iters_started, 20);
        chk("sat4_started_15", q4_iters_started, 15);
        chk("wide_loop_cyc_19", loop_cyc, 19);
        chk("sat4_loop_cyc_15", q4_loop_cyc, 15);
        repeat (20) drive_loop(c_S_ITER, 0, 0, 1, 0);
        chk("wide_ended_20", iters_ended, 20);
        chk("sat4_ended_15", q4_iters_ended, 15);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
